// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pad synchronisers, PS/2 clock glitch filter,
// 11-bit frame deserialiser with parity/stop/timeout checking and a stretched valid strobe.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int VLD_CYCLES  = 4
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_vld,
  output logic [7:0] ps2_data,
  output logic       ps2_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ST_W = $clog2(VLD_CYCLES + 1);
  localparam logic [7:0]      FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ST_W-1:0] ST_LOAD  = ST_W'(VLD_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            filt_clk;
  logic [7:0]      filt_cnt;
  logic            filt_mis, filt_edge, sample;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  state_t          state, state_nx;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par;
  logic            accept, frame_err;
  logic [ST_W-1:0] stretch, stretch_nx;

  // Pads idle high, so the synchronisers reset to 1 to avoid a false start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign filt_mis  = (clk_s2 != filt_clk);
  assign filt_edge = filt_mis && (filt_cnt == FILT_MAX);
  assign sample    = filt_edge && filt_clk;

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (filt_edge) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else if (filt_mis) begin
      filt_cnt <= filt_cnt + 8'd1;
    end else begin
      filt_cnt <= '0;
    end
  end

  // A sample event in the same cycle as the timeout keeps the frame alive.
  assign timeout = (state != IDLE) && (to_cnt == TO_MAX) && !sample;

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (filt_edge || state == IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    frame_err = 1'b0;
    if (timeout) begin
      state_nx  = IDLE;
      frame_err = 1'b1;
    end else if (sample) begin
      case (state)
        IDLE:   if (!dat_s2) state_nx = DATA;
        DATA:   if (bit_cnt == 4'd7) state_nx = PARITY;
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          if (dat_s2 && ^{shreg, par}) accept = 1'b1;
          else                         frame_err = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else if (sample) begin
      case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        PARITY: par <= dat_s2;
        default: ;
      endcase
    end
  end

  always_comb begin
    stretch_nx = stretch;
    if (accept)             stretch_nx = ST_LOAD;
    else if (stretch != '0) stretch_nx = stretch - 1'b1;
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      stretch  <= '0;
      ps2_vld  <= 1'b0;
      ps2_data <= 8'h00;
      ps2_err  <= 1'b0;
    end else begin
      stretch <= stretch_nx;
      ps2_vld <= (stretch_nx != '0);
      ps2_err <= frame_err;
      if (accept) ps2_data <= shreg;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of frames plus hand-written timeout and reset sequences.
// Timeout is scaled down and the PS/2 clock sped up so the run stays short.
module tb_ps2_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 600;
  localparam int VLD_CYCLES  = 4;
  localparam int HALF        = 40;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ps2_vld;
  logic [7:0] ps2_data;
  logic       ps2_err;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .VLD_CYCLES (VLD_CYCLES)
  ) dut (
    .clk50   (clk50),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .ps2_vld (ps2_vld),
    .ps2_data(ps2_data),
    .ps2_err (ps2_err)
  );

  always #10 clk50 = ~clk50;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the inactive clock edge.
  int         vld_pulses = 0, vld_len = 0, vld_run = 0, err_cycles = 0, overlap = 0;
  logic [7:0] data_at_rise = 8'h00;
  logic       vld_q = 1'b0;

  always @(negedge clk50) begin
    if (ps2_vld) begin
      if (!vld_q) data_at_rise = ps2_data;
      vld_run++;
    end else if (vld_q) begin
      vld_pulses++;
      vld_len = vld_run;
      vld_run = 0;
    end
    if (ps2_err) err_cycles++;
    if (ps2_vld && ps2_err) overlap++;
    vld_q = ps2_vld;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit par_flip, input bit stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  // Device drives data while clock is high; receiver samples on the falling edge.
  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      if (glitch && (i == 3 || i == 6)) begin
        repeat (20) @(negedge clk50);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 2) @(negedge clk50);
        ps2_clk = 1'b1;
        repeat (HALF - 20 - (FILTER_LEN - 2)) @(negedge clk50);
      end else begin
        repeat (HALF) @(negedge clk50);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk50);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop, input bit glitch);
    send_bits(mk_frame(d, par_flip, stop), 11, glitch);
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk50);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         par_flip;
    bit         stop;
    bit         glitch;
    int         exp_vld;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, e0, lat;
    bit seen;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1, 0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 0, 8'h1C};
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 0, 1, 8'h1C};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 0, 1, 8'h1C};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1, 0, 8'h5A};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1, 0, 8'h00};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1, 0, 8'hFF};

    repeat (3) @(negedge clk50);
    check("reset_vld", ps2_vld, 0);
    check("reset_data", ps2_data, 8'h00);
    check("reset_err", ps2_err, 0);
    reset = 1'b1;
    repeat (20) @(negedge clk50);

    for (int v = 0; v < 8; v++) begin
      p0 = vld_pulses;
      e0 = err_cycles;
      send_frame(vecs[v].d, vecs[v].par_flip, vecs[v].stop, vecs[v].glitch);
      check($sformatf("vec%0d_vld_pulses", v), vld_pulses - p0, vecs[v].exp_vld);
      check($sformatf("vec%0d_err_cycles", v), err_cycles - e0, vecs[v].exp_err);
      check($sformatf("vec%0d_data", v), ps2_data, vecs[v].exp_data);
      if (vecs[v].exp_vld != 0) begin
        check($sformatf("vec%0d_vld_len", v), vld_len, VLD_CYCLES);
        check($sformatf("vec%0d_data_at_vld_rise", v), data_at_rise, vecs[v].exp_data);
      end
    end

    // Stall after start + 5 data bits: one error pulse ~TIMEOUT_CYC after the last clock edge.
    p0 = vld_pulses;
    e0 = err_cycles;
    send_bits(mk_frame(8'hB3, 1'b0, 1'b1), 6, 1'b0);
    ps2_dat = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= TIMEOUT_CYC + 100; i++) begin
      @(negedge clk50);
      if (ps2_err && !seen) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("timeout_err_seen", seen, 1);
    check("timeout_latency_window", (lat >= TIMEOUT_CYC + 8) && (lat <= TIMEOUT_CYC + 12), 1);
    check("timeout_err_cycles", err_cycles - e0, 1);
    check("timeout_no_vld", vld_pulses - p0, 0);
    check("timeout_data_kept", ps2_data, 8'hFF);

    p0 = vld_pulses;
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("after_timeout_vld", vld_pulses - p0, 1);
    check("after_timeout_data", ps2_data, 8'h29);

    // Reset after data bit 4, then a clean frame.
    p0 = vld_pulses;
    e0 = err_cycles;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk50);
    check("midreset_vld", ps2_vld, 0);
    check("midreset_data", ps2_data, 8'h00);
    check("midreset_err", ps2_err, 0);
    ps2_dat = 1'b1;
    reset = 1'b1;
    repeat (20) @(negedge clk50);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("post_reset_no_err", err_cycles - e0, 0);
    check("post_reset_vld", vld_pulses - p0, 1);
    check("post_reset_vld_len", vld_len, VLD_CYCLES);
    check("post_reset_data", ps2_data, 8'h1C);

    check("vld_err_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host receiver feeding the keyboard scan-code connector stage. It synchronises the raw `ps2_clk`/`ps2_dat` pad signals into the `clk50` domain and glitch-filters the PS/2 clock. It deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents each good byte on `ps2_data` with a stretched `ps2_vld` strobe. Malformed or stalled frames are dropped, with a one-cycle `ps2_err` pulse.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before filtered PS/2 clock changes level (2..255).
- `TIMEOUT_CYC`, 50000: clk50 cycles without a filtered PS/2 clock edge that abort an in-progress frame (1 ms at 50 MHz).
- `VLD_CYCLES`, 4: number of clk50 cycles `ps2_vld` stays high per accepted byte (≥2, so the downstream rising-edge detector sees it).
- `clk50` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pad, asynchronous.
- `ps2_dat` in 1: raw PS/2 data pad, asynchronous.
- `ps2_vld` out 1: high for `VLD_CYCLES` cycles when a byte is accepted.
- `ps2_data` out 8: last accepted byte; held until the next accepted byte.
- `ps2_err` out 1: one-cycle pulse on parity error, stop error or timeout.

## Operation
- Both pad inputs go through 2-FF synchronisers, reset to 1.
- Filter: counter compares synced clk to filtered clk (reset 1). On mismatch the counter increments, and it clears on match. When the count reaches `FILTER_LEN`-1 on a mismatching sample, filtered clk takes the new value and the counter clears.
- Sample event: the cycle in which filtered clk goes 1→0. Synced data is sampled in that cycle.
- FSM states IDLE, DATA, PARITY, STOP. 4-bit bit counter, 8-bit shift register (shift right, new bit into bit 7).
  - IDLE: sample=0 → DATA, bit counter cleared. sample=1 → stay, no error.
  - DATA: shift in sample. After the 8th bit → PARITY.
  - PARITY: store sample as p → STOP.
  - STOP: accept if sample=1 and XOR(shreg, p)=1. Otherwise pulse `ps2_err`. Always → IDLE.
- On accept:
  - `ps2_data` ← shreg.
  - Stretch counter loads `VLD_CYCLES`.
  - `ps2_vld` = (stretch counter ≠ 0), registered.
- Accept while the stretch is still active reloads the counter and updates data. This cannot occur at legal PS/2 rates; no special handling.
- Timeout counter clears on every filtered edge (either direction) and while in IDLE. It saturates otherwise. Reaching `TIMEOUT_CYC`-1 outside IDLE forces IDLE and pulses `ps2_err`. Shifted data is discarded.
- A timeout and a sample event in the same cycle: the sample event wins, and the timeout counter clears.
- `ps2_data` is never modified on error. `ps2_vld` and `ps2_err` are never high in the same cycle.

## Timing
- Reset values:
  - `ps2_vld`=0, `ps2_data`=8'h00, `ps2_err`=0.
  - FSM=IDLE.
  - Filter, timeout and stretch counters = 0.
  - Synchronisers and filtered clk = 1.
- Pad edge to sample event: 2 sync cycles + `FILTER_LEN` cycles (10 with defaults), ±1 cycle for pad asynchrony.
- Stop-bit sample event in cycle N:
  - Accept: `ps2_data` and `ps2_vld` change at the edge ending cycle N, and `ps2_vld` is high for cycles N+1..N+`VLD_CYCLES`.
  - Error: `ps2_err` is high in cycle N+1 only.
- Reset asserted mid-frame: immediate return to reset values. After release, the next start bit begins a fresh frame and no error is reported for the aborted one.
- No back-pressure: downstream must consume within one frame time (~0.6 ms minimum).

## Test plan
- Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz PS/2 clock → `ps2_data`=0x1C, `ps2_vld` high exactly 4 cycles, `ps2_err` stays 0.
- Back-to-back frames 0x1C, 0xF0 (parity 1), 0x1C → three separate 4-cycle `ps2_vld` pulses, with `ps2_data` sequence 0x1C, 0xF0, 0x1C.
- 0x1C sent with parity 1, then a frame with stop bit 0 → two 1-cycle `ps2_err` pulses, no `ps2_vld`, `ps2_data` keeps its prior value.
- Low glitches on `ps2_clk` of `FILTER_LEN`-2 cycles inserted mid-frame 0x5A → glitches ignored, 0x5A received correctly.
- Send start plus 5 data bits, then hold `ps2_clk` high for `TIMEOUT_CYC`+10 cycles → one `ps2_err` pulse at the timeout, FSM in IDLE. A following valid 0x29 frame is received.
- Assert `reset` after bit 4 of a frame, release, then send 0x1C → outputs at reset values, no `ps2_err`, then 0x1C accepted normally.
